// File: rtl/ibex_neur_pkg.sv
// ibex_neur_pkg
// Shared types and constants for the packed mixed-precision MAC sequencer.
//   neur_prec_e      : element precision of a packed 32b word
//   neur_seq_state_e : sequencer FSM states
//   NEUR_LANES       : lanes of the shared signed multiplier
//   NEUR_MODE_MAC    : multiplier mode code for signed 4-lane operation
//   beats_per_word() : multiplier beats needed to consume one word pair
package ibex_neur_pkg;

  typedef enum logic [1:0] {
    NEUR_P16 = 2'd0,
    NEUR_P8  = 2'd1,
    NEUR_P4  = 2'd2,
    NEUR_P2  = 2'd3
  } neur_prec_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } neur_seq_state_e;

  localparam int unsigned NEUR_LANES    = 4;
  localparam logic [1:0]  NEUR_MODE_MAC = 2'd1;

  // A word holds 2/4/8/16 elements and each beat consumes up to four of
  // them, so 16b and 8b need one beat, 4b two and 2b four.
  function automatic logic [2:0] beats_per_word(input neur_prec_e prec);
    logic [2:0] beats;
    unique case (prec)
      NEUR_P16: beats = 3'd1;
      NEUR_P8:  beats = 3'd1;
      NEUR_P4:  beats = 3'd2;
      default:  beats = 3'd4;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ibex_neur_unpack.sv
// ibex_neur_unpack
// Combinational unpacker: selects the four elements of a packed word that
// belong to the given beat and sign-extends each to 16 bits.
//   word_i  : packed 32b activation or weight word
//   prec_i  : element precision
//   beat_i  : beat index within the word (element 4*beat+lane feeds lane)
//   lane_o  : four sign-extended 16b lane operands (lanes 2,3 zero at 16b)
module ibex_neur_unpack
  import ibex_neur_pkg::*;
(
  input  logic [31:0]                 word_i,
  input  neur_prec_e                  prec_i,
  input  logic [1:0]                  beat_i,
  output logic [NEUR_LANES-1:0][15:0] lane_o
);

  for (genvar l = 0; l < NEUR_LANES; l++) begin : g_lane
    logic [3:0]  elem;
    logic [5:0]  shamt;
    logic [15:0] shifted;
    logic [15:0] lane;

    assign elem = {beat_i, 2'(l)};

    // Bit offset of the element is elem*W. The elem bits that can never be
    // set at a given precision are dropped so the offset stays below 32.
    always_comb begin
      shamt   = '0;
      lane    = '0;
      unique case (prec_i)
        NEUR_P16: shamt = {1'b0, elem[0], 4'b0000};
        NEUR_P8:  shamt = {1'b0, elem[1:0], 3'b000};
        NEUR_P4:  shamt = {elem[2:0], 3'b000} >> 1;
        default:  shamt = {elem[3:0], 1'b0};
      endcase
      shifted = 16'(word_i >> shamt);
      unique case (prec_i)
        NEUR_P16: lane = (elem[3:1] == 3'd0) ? shifted : 16'd0;
        NEUR_P8:  lane = {{8{shifted[7]}}, shifted[7:0]};
        NEUR_P4:  lane = {{12{shifted[3]}}, shifted[3:0]};
        default:  lane = {{14{shifted[1]}}, shifted[1:0]};
      endcase
    end

    assign lane_o[l] = lane;
  end

endmodule

// File: rtl/ibex_neur_mac_seq.sv
// ibex_neur_mac_seq
// Sequences packed mixed-precision dot products onto the shared 4-lane
// signed multiplier. Word pairs are held one at a time, unpacked per beat
// and issued whenever the core is not using the multiplier; the lane sums
// are accumulated onto the job bias and one 32b result is returned per job.
// Build option: define IBEX_NEUR_SAT_EN for a saturating accumulator,
// otherwise the accumulator wraps in two's complement.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   start_i/prec_i/len_i/bias_i : job start (accepted in IDLE only)
//   in_valid_i/in_ready_o/in_act_i/in_wgt_i : packed word pair stream
//   core_mul_req_i        : core claims the multiplier (always wins)
//   neur_mul_en_o/neur_mode_o/neur_oper_*_o : multiplier issue
//   neur_mul_res_i        : lane-sum result in the issue cycle
//   res_valid_o/res_ready_i/res_o : job result handshake
//   busy_o                : sequencer not idle
module ibex_neur_mac_seq
  import ibex_neur_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       prec_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      bias_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_act_i,
  input  logic [31:0]      in_wgt_i,
  input  logic             core_mul_req_i,
  output logic             neur_mul_en_o,
  output logic [1:0]       neur_mode_o,
  output logic [15:0]      neur_oper_a0_o,
  output logic [15:0]      neur_oper_a1_o,
  output logic [15:0]      neur_oper_a2_o,
  output logic [15:0]      neur_oper_a3_o,
  output logic [15:0]      neur_oper_b0_o,
  output logic [15:0]      neur_oper_b1_o,
  output logic [15:0]      neur_oper_b2_o,
  output logic [15:0]      neur_oper_b3_o,
  input  logic [31:0]      neur_mul_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic             busy_o
);

  neur_seq_state_e             state_q;
  neur_prec_e                  prec_q;
  logic [31:0]                 acc_q;
  logic [31:0]                 act_q;
  logic [31:0]                 wgt_q;
  logic [LEN_W-1:0]            words_left_q;
  logic [1:0]                  beat_q;
  logic                        full_q;

  logic [NEUR_LANES-1:0][15:0] act_lanes;
  logic [NEUR_LANES-1:0][15:0] wgt_lanes;
  logic                        grant;
  logic                        last_beat;
  logic                        more_words;
  logic                        retire;
  logic                        in_fire;
  logic [31:0]                 acc_next;

  ibex_neur_unpack u_unpack_act (
    .word_i (act_q),
    .prec_i (prec_q),
    .beat_i (beat_q),
    .lane_o (act_lanes)
  );

  ibex_neur_unpack u_unpack_wgt (
    .word_i (wgt_q),
    .prec_i (prec_q),
    .beat_i (beat_q),
    .lane_o (wgt_lanes)
  );

  // The core has priority: a held word only issues when the core is not
  // requesting. A retiring word frees the holding register in the same
  // cycle, so the next pair can be accepted without a bubble as long as
  // more words of the job are still expected.
  assign grant      = (state_q == RUN) & full_q & ~core_mul_req_i;
  assign last_beat  = ({1'b0, beat_q} == (beats_per_word(prec_q) - 3'd1));
  assign more_words = words_left_q > LEN_W'(1);
  assign retire     = grant & last_beat;
  assign in_ready_o = (state_q == RUN) & (~full_q | (retire & more_words));
  assign in_fire    = in_valid_i & in_ready_o;

  assign neur_mul_en_o  = grant;
  assign neur_mode_o    = NEUR_MODE_MAC;
  assign neur_oper_a0_o = grant ? act_lanes[0] : 16'd0;
  assign neur_oper_a1_o = grant ? act_lanes[1] : 16'd0;
  assign neur_oper_a2_o = grant ? act_lanes[2] : 16'd0;
  assign neur_oper_a3_o = grant ? act_lanes[3] : 16'd0;
  assign neur_oper_b0_o = grant ? wgt_lanes[0] : 16'd0;
  assign neur_oper_b1_o = grant ? wgt_lanes[1] : 16'd0;
  assign neur_oper_b2_o = grant ? wgt_lanes[2] : 16'd0;
  assign neur_oper_b3_o = grant ? wgt_lanes[3] : 16'd0;

  assign res_valid_o = (state_q == DONE);
  assign res_o       = (state_q == DONE) ? acc_q : 32'd0;
  assign busy_o      = (state_q != IDLE);

`ifdef IBEX_NEUR_SAT_EN
  // Saturating accumulate: overflow shows up as a mismatch between the
  // two top bits of the sign-extended 33b sum.
  logic [32:0] sum33;
  always_comb begin
    sum33    = {acc_q[31], acc_q} + {neur_mul_res_i[31], neur_mul_res_i};
    acc_next = sum33[31:0];
    if (sum33[32] != sum33[31]) begin
      acc_next = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end
`else
  // Wrapping accumulate.
  always_comb begin
    acc_next = acc_q + neur_mul_res_i;
  end
`endif

  // Sequencer FSM. In RUN the beat counter advances on every granted
  // beat, restarts on retire, and a newly accepted word always starts at
  // beat 0 (that assignment comes last so it overrides the others).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      prec_q       <= NEUR_P16;
      acc_q        <= '0;
      act_q        <= '0;
      wgt_q        <= '0;
      words_left_q <= '0;
      beat_q       <= '0;
      full_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            acc_q        <= bias_i;
            words_left_q <= len_i;
            prec_q       <= neur_prec_e'(prec_i);
            beat_q       <= '0;
            full_q       <= 1'b0;
            state_q      <= (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (grant) begin
            acc_q  <= acc_next;
            beat_q <= beat_q + 2'd1;
          end
          if (retire) begin
            words_left_q <= words_left_q - LEN_W'(1);
            beat_q       <= '0;
            full_q       <= 1'b0;
            if (!more_words) begin
              state_q <= DONE;
            end
          end
          if (in_fire) begin
            act_q  <= in_act_i;
            wgt_q  <= in_wgt_i;
            beat_q <= '0;
            full_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_neur_mac_seq.sv
// tb_ibex_neur_mac_seq
// Self-checking bench for ibex_neur_mac_seq. Models the shared multiplier
// as a combinational lane-sum, keeps a scoreboard of expected job results
// and compares each result as it is handed over.
module tb_ibex_neur_mac_seq;
  import ibex_neur_pkg::*;

  localparam int LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [1:0]       prec_i;
  logic [LEN_W-1:0] len_i;
  logic [31:0]      bias_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_act_i;
  logic [31:0]      in_wgt_i;
  logic             core_mul_req_i;
  logic             neur_mul_en_o;
  logic [1:0]       neur_mode_o;
  logic [15:0]      a0, a1, a2, a3, b0, b1, b2, b3;
  logic [31:0]      neur_mul_res_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_o;
  logic             busy_o;

  int               check_count   = 0;
  int               fail_count    = 0;
  int               extra_results = 0;
  int               beat_count    = 0;
  logic [1:0]       cur_prec      = 2'd0;
  logic [31:0]      sb[$];
  logic [31:0]      act_words[8];
  logic [31:0]      wgt_words[8];

  ibex_neur_mac_seq #(.LEN_W(LEN_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .prec_i         (prec_i),
    .len_i          (len_i),
    .bias_i         (bias_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_act_i       (in_act_i),
    .in_wgt_i       (in_wgt_i),
    .core_mul_req_i (core_mul_req_i),
    .neur_mul_en_o  (neur_mul_en_o),
    .neur_mode_o    (neur_mode_o),
    .neur_oper_a0_o (a0),
    .neur_oper_a1_o (a1),
    .neur_oper_a2_o (a2),
    .neur_oper_a3_o (a3),
    .neur_oper_b0_o (b0),
    .neur_oper_b1_o (b1),
    .neur_oper_b2_o (b2),
    .neur_oper_b3_o (b3),
    .neur_mul_res_i (neur_mul_res_i),
    .res_valid_o    (res_valid_o),
    .res_ready_i    (res_ready_i),
    .res_o          (res_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Multiplier model: signed lane products summed in the issue cycle.
  logic signed [31:0] p0, p1, p2, p3;
  assign p0 = $signed(a0) * $signed(b0);
  assign p1 = $signed(a1) * $signed(b1);
  assign p2 = $signed(a2) * $signed(b2);
  assign p3 = $signed(a3) * $signed(b3);
  assign neur_mul_res_i = p0 + p1 + p2 + p3;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Element e of width wd, sign-extended, extracted by shifting it to the
  // top of the word and arithmetic-shifting it back down.
  function automatic logic signed [31:0] elemOf(input logic [31:0] w, input int e, input int wd);
    logic [31:0] t;
    t = w << (32 - wd * (e + 1));
    return $signed(t) >>> (32 - wd);
  endfunction

  function automatic logic [31:0] accumulate(input logic [31:0] a, input logic signed [31:0] s);
`ifdef IBEX_NEUR_SAT_EN
    longint sum;
    sum = longint'($signed(a)) + longint'(s);
    if (sum > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (sum < -64'sh8000_0000) return 32'h8000_0000;
    return 32'(sum);
`else
    return a + s;
`endif
  endfunction

  function automatic logic [31:0] modelJob(input logic [1:0] prec, input int len, input logic [31:0] bias);
    int wd;
    int ne;
    logic [31:0] acc;
    logic signed [31:0] s;
    wd  = 16 >> prec;
    ne  = 32 / wd;
    acc = bias;
    for (int w = 0; w < len; w++) begin
      for (int b = 0; b < (ne + 3) / 4; b++) begin
        s = 0;
        for (int l = 0; l < 4; l++) begin
          if (4 * b + l < ne) begin
            s = s + elemOf(act_words[w], 4 * b + l, wd) * elemOf(wgt_words[w], 4 * b + l, wd);
          end
        end
        acc = accumulate(acc, s);
      end
    end
    return acc;
  endfunction

  // Result monitor and per-beat checks, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (neur_mul_en_o) begin
      beat_count++;
      checkOutput("issue_mode", {62'd0, neur_mode_o}, 64'd1);
      if (cur_prec == 2'd0) begin
        checkOutput("p16_upper_lanes", {a2, a3, b2, b3}, 64'd0);
      end
    end
    if (res_valid_o && res_ready_i) begin
      if (sb.size() > 0) begin
        checkOutput("result", {32'd0, res_o}, {32'd0, sb.pop_front()});
      end else begin
        extra_results++;
      end
    end
  end

  task automatic drainScoreboard();
    int waited;
    waited = 0;
    while (sb.size() > 0 && waited < 50) begin
      @(posedge clk_i); #1;
      waited++;
    end
    checkOutput("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  // Runs one job: words come from act_words/wgt_words, the expected result
  // goes on the scoreboard, and an optional core stall of stall_len cycles
  // starts stall_at edges after the start edge. lat = edges after the
  // start edge before res_valid_o is seen. Entered and left at posedge+1.
  task automatic applyStimulus(input logic [1:0] prec, input int len, input logic [31:0] bias,
                               input logic [31:0] exp_res, input int stall_at, input int stall_len,
                               output int lat);
    int beats_exp;
    int l_lat;
    beats_exp = len * ((32 / (16 >> prec) + 3) / 4);
    sb.push_back(exp_res);
    cur_prec = prec;
    start_i  = 1'b1;
    prec_i   = prec;
    len_i    = LEN_W'(len);
    bias_i   = bias;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    beat_count = 0;
    l_lat      = 0;
    fork
      begin : feed
        for (int w = 0; w < len; w++) begin
          bit accepted;
          int waited;
          accepted   = 1'b0;
          waited     = 0;
          in_valid_i = 1'b1;
          in_act_i   = act_words[w];
          in_wgt_i   = wgt_words[w];
          while (!accepted && waited < 100) begin
            @(negedge clk_i);
            accepted = in_ready_o;
            @(posedge clk_i); #1;
            waited++;
          end
          checkOutput("feed_accept", {63'd0, accepted}, 64'd1);
        end
        in_valid_i = 1'b0;
      end
      begin : stall
        if (stall_len > 0) begin
          repeat (stall_at) @(posedge clk_i);
          #1;
          for (int k = 0; k < stall_len; k++) begin
            core_mul_req_i = 1'b1;
            @(negedge clk_i);
            checkOutput("stall_no_issue", {63'd0, neur_mul_en_o}, 64'd0);
            @(posedge clk_i); #1;
          end
          core_mul_req_i = 1'b0;
        end
      end
      begin : watch
        bit seen;
        seen = 1'b0;
        while (!seen && l_lat < 300) begin
          @(negedge clk_i);
          if (res_valid_o) seen = 1'b1;
          else begin
            @(posedge clk_i);
            l_lat++;
          end
        end
        checkOutput("result_arrives", {63'd0, seen}, 64'd1);
        @(posedge clk_i); #1;
      end
    join
    lat = l_lat;
    checkOutput("beat_count", 64'(beat_count), 64'(beats_exp));
    if (res_ready_i) drainScoreboard();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int lat_ref;
    logic [31:0] exp_hold;
    rst_i          = 1'b1;
    start_i        = 1'b0;
    prec_i         = 2'd0;
    len_i          = '0;
    bias_i         = '0;
    in_valid_i     = 1'b0;
    in_act_i       = '0;
    in_wgt_i       = '0;
    core_mul_req_i = 1'b0;
    res_ready_i    = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_ctrl", {26'd0, busy_o, res_valid_o, in_ready_o, neur_mul_en_o, neur_mode_o, res_o},
                {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0});
    checkOutput("reset_oper_a", {a0, a1, a2, a3}, 64'd0);
    checkOutput("reset_oper_b", {b0, b1, b2, b3}, 64'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    $display("[TB] 8b single word");
    act_words[0] = 32'h0102_0304; wgt_words[0] = 32'h0101_0101;
    applyStimulus(2'd1, 1, 32'd0, 32'd10, 0, 0, lat);

    $display("[TB] 16b single word");
    act_words[0] = 32'hFFFF_0002; wgt_words[0] = 32'h0003_0005;
    applyStimulus(2'd0, 1, 32'd0, 32'd7, 0, 0, lat);

    $display("[TB] 2b two words with bias");
    act_words[0] = 32'hFFFF_FFFF; wgt_words[0] = 32'h5555_5555;
    act_words[1] = 32'hFFFF_FFFF; wgt_words[1] = 32'h5555_5555;
    applyStimulus(2'd3, 2, 32'd5, 32'hFFFF_FFE5, 0, 0, lat);

    $display("[TB] 4b contention");
    for (int w = 0; w < 3; w++) begin
      act_words[w] = 32'h1111_1111; wgt_words[w] = 32'h2222_2222;
    end
    applyStimulus(2'd2, 3, 32'd0, 32'd48, 0, 0, lat_ref);
    applyStimulus(2'd2, 3, 32'd0, 32'd48, 3, 3, lat);
    checkOutput("stall_latency", 64'(lat), 64'(lat_ref + 3));

    $display("[TB] accumulator overflow");
    act_words[0] = 32'h7F7F_7F7F; wgt_words[0] = 32'h7F7F_7F7F;
`ifdef IBEX_NEUR_SAT_EN
    applyStimulus(2'd1, 1, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 0, 0, lat);
`else
    applyStimulus(2'd1, 1, 32'h7FFF_FFF0, 32'h8000_FBF4, 0, 0, lat);
`endif

    $display("[TB] zero-length job");
    applyStimulus(2'd1, 0, 32'h1234, 32'h1234, 0, 0, lat);
    checkOutput("len0_latency", 64'(lat), 64'd0);

    $display("[TB] result held while not ready");
    act_words[0] = $urandom; wgt_words[0] = $urandom;
    act_words[1] = $urandom; wgt_words[1] = $urandom;
    exp_hold    = modelJob(2'd1, 2, 32'hABCD);
    res_ready_i = 1'b0;
    applyStimulus(2'd1, 2, 32'hABCD, exp_hold, 0, 0, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checkOutput("hold_valid", {63'd0, res_valid_o}, 64'd1);
      checkOutput("hold_res", {32'd0, res_o}, {32'd0, exp_hold});
      @(posedge clk_i); #1;
    end
    res_ready_i = 1'b1;
    drainScoreboard();

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      logic [1:0]  rp;
      int          rl;
      logic [31:0] rb;
      rp = 2'($urandom_range(0, 3));
      rl = $urandom_range(1, 4);
      rb = $urandom;
      for (int w = 0; w < rl; w++) begin
        act_words[w] = $urandom; wgt_words[w] = $urandom;
      end
      applyStimulus(rp, rl, rb, modelJob(rp, rl, rb), $urandom_range(1, 4), $urandom_range(0, 3), lat);
    end

    $display("[TB] reset mid-run");
    cur_prec = 2'd1;
    start_i  = 1'b1; prec_i = 2'd1; len_i = LEN_W'(3); bias_i = 32'h55;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    in_valid_i = 1'b1; in_act_i = 32'h0102_0304; in_wgt_i = 32'h0506_0708;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    checkOutput("midrun_reset_ctrl", {26'd0, busy_o, res_valid_o, in_ready_o, neur_mul_en_o, neur_mode_o, res_o},
                {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 32'd0});
    checkOutput("midrun_reset_oper_a", {a0, a1, a2, a3}, 64'd0);
    checkOutput("midrun_reset_oper_b", {b0, b1, b2, b3}, 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    checkOutput("idle_after_reset", {63'd0, busy_o}, 64'd0);
    checkOutput("no_extra_results", 64'(extra_results), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
